// File: rtl/craps_ctrl_pkg.sv
// Shared types and constants for the craps game sequencer (craps_ctrl).
// Optional roll counter enabled by defining CRAPS_ROLL_COUNT_EN.
package craps_pkg;

  typedef enum logic [2:0] {
    COME_OUT = 3'd0,
    POINT    = 3'd1,
    EVAL     = 3'd2,
    WIN      = 3'd3,
    LOSE     = 3'd4
  } state_t;

  localparam logic [3:0] SUM_NATURAL7  = 4'd7;
  localparam logic [3:0] SUM_NATURAL11 = 4'd11;
  localparam logic [3:0] SUM_CRAPS2    = 4'd2;
  localparam logic [3:0] SUM_CRAPS3    = 4'd3;
  localparam logic [3:0] SUM_CRAPS12   = 4'd12;

  localparam int DIE_MIN = 1;
  localparam int DIE_MAX = 6;

endpackage

// File: rtl/craps_ctrl_if.sv
// Board-side signal bundle of the craps sequencer (craps_ctrl).
// roll_cnt exists only when CRAPS_ROLL_COUNT_EN is defined.
interface craps_ctrl_if
  import craps_pkg::*;
#(
  parameter int DIE_W = 3
);
  // Signalling: there is no valid/ready pair. rb/counter are sampled every
  // clock; every output is a registered level that changes only on a clock
  // edge. A roll result is presented on the edge where dbg_state leaves EVAL.
  logic [1:0]       rb;
  logic [DIE_W-1:0] counter;
  logic [DIE_W-1:0] dice1;
  logic [DIE_W-1:0] dice2;
  logic [3:0]       point;
  logic             win;
  logic             lose;
  logic             sel;
  logic             busy;
  state_t           dbg_state;
`ifdef CRAPS_ROLL_COUNT_EN
  logic [3:0]       roll_cnt;
`endif

  modport master (
    output rb, counter,
    input  dice1, dice2, point, win, lose, sel, busy, dbg_state
`ifdef CRAPS_ROLL_COUNT_EN
    , input roll_cnt
`endif
  );

  modport slave (
    input  rb, counter,
    output dice1, dice2, point, win, lose, sel, busy, dbg_state
`ifdef CRAPS_ROLL_COUNT_EN
    , output roll_cnt
`endif
  );

endinterface

// File: rtl/craps_ctrl_btn_fall.sv
// Falling-edge (press) detector for one active-low debounced button.
// History resets to "released" so a button held through reset presses once.
module btn_fall (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_press
);

  logic r_prev;

  // Remember last cycle's button level; reset to released (1).
  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b1;
    else       r_prev <= i_btn_n;
  end

  assign o_press = r_prev & ~i_btn_n;

endmodule

// File: rtl/craps_ctrl.sv
// Craps game sequencer: captures one value per die per roll, applies
// come-out/point rules, drives win/lose, dice values and 7-seg digit select.
// Optional: define CRAPS_ROLL_COUNT_EN to add a saturating roll counter.
module craps_ctrl
  import craps_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int DIE_W    = 3
) (
  input logic          mHz,
  input logic          reset,
  craps_ctrl_if.slave  bus
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t           r_state, w_state_nxt;
  logic [DIE_W-1:0] r_dice1, r_dice2, w_dice1_nxt, w_dice2_nxt;
  logic [3:0]       r_point, w_point_nxt;
  logic             r_win, r_lose;
  logic [1:0]       r_captured, w_captured_nxt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic             r_sel;
  logic [1:0]       w_press;
  logic [DIE_W-1:0] w_die_val;
  logic [3:0]       w_sum;

  btn_fall u_fall0 (.i_clk(mHz), .i_rst(reset), .i_btn_n(bus.rb[0]), .o_press(w_press[0]));
  btn_fall u_fall1 (.i_clk(mHz), .i_rst(reset), .i_btn_n(bus.rb[1]), .o_press(w_press[1]));

  // Out-of-range counter values (0, 7) are forced to 1 so sums stay 2..12.
  always_comb begin
    w_die_val = bus.counter;
    if (bus.counter < DIE_W'(DIE_MIN) || bus.counter > DIE_W'(DIE_MAX))
      w_die_val = DIE_W'(DIE_MIN);
  end

  assign w_sum = 4'(r_dice1) + 4'(r_dice2);

  // Next-state and next-register logic for the game FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_dice1_nxt    = r_dice1;
    w_dice2_nxt    = r_dice2;
    w_point_nxt    = r_point;
    w_captured_nxt = r_captured;
    case (r_state)
      COME_OUT, POINT: begin
        if (r_captured == 2'b11) begin
          w_state_nxt    = EVAL;
          w_captured_nxt = 2'b00;
        end else begin
          if (w_press[0] && !r_captured[0]) begin
            w_dice1_nxt       = w_die_val;
            w_captured_nxt[0] = 1'b1;
          end
          if (w_press[1] && !r_captured[1]) begin
            w_dice2_nxt       = w_die_val;
            w_captured_nxt[1] = 1'b1;
          end
        end
      end
      EVAL: begin
        // point==0 marks the come-out phase; an established point is 4..10.
        if (r_point == 4'd0) begin
          if (w_sum == SUM_NATURAL7 || w_sum == SUM_NATURAL11)
            w_state_nxt = WIN;
          else if (w_sum == SUM_CRAPS2 || w_sum == SUM_CRAPS3 || w_sum == SUM_CRAPS12)
            w_state_nxt = LOSE;
          else begin
            w_point_nxt = w_sum;
            w_state_nxt = POINT;
          end
        end else begin
          if (w_sum == r_point)           w_state_nxt = WIN;
          else if (w_sum == SUM_NATURAL7) w_state_nxt = LOSE;
          else                            w_state_nxt = POINT;
        end
      end
      WIN, LOSE: begin
        // A press here only starts a new game; it is not a roll.
        if (|w_press) begin
          w_state_nxt = COME_OUT;
          w_dice1_nxt = '0;
          w_dice2_nxt = '0;
          w_point_nxt = 4'd0;
        end
      end
      default: w_state_nxt = COME_OUT;
    endcase
  end

  // Game state and result registers.
  always_ff @(posedge mHz) begin
    if (reset) begin
      r_state    <= COME_OUT;
      r_dice1    <= '0;
      r_dice2    <= '0;
      r_point    <= 4'd0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
      r_captured <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_dice1    <= w_dice1_nxt;
      r_dice2    <= w_dice2_nxt;
      r_point    <= w_point_nxt;
      r_win      <= (w_state_nxt == WIN);
      r_lose     <= (w_state_nxt == LOSE);
      r_captured <= w_captured_nxt;
    end
  end

  // Display scan: toggle the digit select every SCAN_DIV cycles.
  always_ff @(posedge mHz) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_sel      <= 1'b0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_sel      <= ~r_sel;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

`ifdef CRAPS_ROLL_COUNT_EN
  logic [3:0] r_roll_cnt;

  // Count evaluated rolls per game, saturating at 15.
  always_ff @(posedge mHz) begin
    if (reset)
      r_roll_cnt <= 4'd0;
    else if ((r_state == WIN || r_state == LOSE) && w_state_nxt == COME_OUT)
      r_roll_cnt <= 4'd0;
    else if (w_state_nxt == EVAL && r_state != EVAL && r_roll_cnt != 4'd15)
      r_roll_cnt <= r_roll_cnt + 4'd1;
  end

  assign bus.roll_cnt = r_roll_cnt;
`endif

  assign bus.dice1     = r_dice1;
  assign bus.dice2     = r_dice2;
  assign bus.point     = r_point;
  assign bus.win       = r_win;
  assign bus.lose      = r_lose;
  assign bus.sel       = r_sel;
  assign bus.busy      = r_captured[0] ^ r_captured[1];
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_craps_ctrl.sv
// Testbench for craps_ctrl (SCAN_DIV=4): directed rolls, expected results
// queued by the driver and popped by a monitor when a roll resolves.
module tb_craps_ctrl;
  import craps_pkg::*;

  localparam int W = 12;  // {dice1, dice2, point, win, lose}

  logic mHz;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W-1:0] exp_q[$];
  state_t prev_state;

  craps_ctrl_if #(.DIE_W(3)) bus ();

  craps_ctrl #(.SCAN_DIV(4), .DIE_W(3)) dut (
    .mHz   (mHz),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    mHz = 1'b0;
    forever #5 mHz = ~mHz;
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pack(input logic [2:0] d1, input logic [2:0] d2,
                                         input logic [3:0] p, input logic w, input logic l);
    return {d1, d2, p, w, l};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.dice1, bus.dice2, bus.point, bus.win, bus.lose};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge mHz);
  endtask

  // Press the buttons in mask for one cycle with the given counter, then release.
  task automatic press(input logic [1:0] mask, input logic [2:0] val);
    bus.counter = val;
    bus.rb      = ~mask;
    cyc();
    bus.rb      = 2'b11;
    cyc();
  endtask

  task automatic roll(input logic [2:0] a, input logic [2:0] b, input logic [W-1:0] exp);
    press(2'b01, a);
    exp_q.push_back(exp);
    press(2'b10, b);
    cyc(3);
  endtask

  task automatic new_game(input string name);
    press(2'b01, 3'd3);
    chk({name, "_outputs"}, 32'(observed()), 32'(pack(3'd0, 3'd0, 4'd0, 1'b0, 1'b0)));
    chk({name, "_state"}, 32'(bus.dbg_state), 32'(COME_OUT));
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge mHz) begin
    if (!reset && prev_state == EVAL && bus.dbg_state != EVAL) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL roll_result: got %0h with no roll expected", observed());
      end else begin
        chk("roll_result", 32'(observed()), 32'(exp_q.pop_front()));
      end
    end
    prev_state = reset ? COME_OUT : bus.dbg_state;
  end

  // ---------------- stimulus ----------------
  initial begin
    prev_state  = COME_OUT;
    reset       = 1'b1;
    bus.rb      = 2'b11;
    bus.counter = 3'd1;
    cyc(3);
    reset = 1'b0;

    // reset state
    chk("reset_outputs", 32'(observed()), 32'(pack(3'd0, 3'd0, 4'd0, 1'b0, 1'b0)));
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_sel", 32'(bus.sel), 32'd0);
    chk("reset_state", 32'(bus.dbg_state), 32'(COME_OUT));

    // display select: toggles after edge 4, again after edge 8
    cyc(3); chk("sel_k3", 32'(bus.sel), 32'd0);
    cyc(1); chk("sel_k4", 32'(bus.sel), 32'd1);
    cyc(3); chk("sel_k7", 32'(bus.sel), 32'd1);
    cyc(1); chk("sel_k8", 32'(bus.sel), 32'd0);

    // come-out natural 3+4, with explicit latency checks
    bus.counter = 3'd3; bus.rb = 2'b10; cyc();
    chk("nat_dice1", 32'(bus.dice1), 32'd3);
    chk("nat_busy_one", 32'(bus.busy), 32'd1);
    bus.rb = 2'b11; cyc();
    exp_q.push_back(pack(3'd3, 3'd4, 4'd0, 1'b1, 1'b0));
    bus.counter = 3'd4; bus.rb = 2'b01; cyc();          // edge N
    chk("nat_dice2", 32'(bus.dice2), 32'd4);
    chk("nat_busy_both", 32'(bus.busy), 32'd0);
    cyc();                                             // edge N+1
    chk("nat_eval_state", 32'(bus.dbg_state), 32'(EVAL));
    chk("nat_win_early", 32'(bus.win), 32'd0);
    cyc();                                             // edge N+2
    chk("nat_win", 32'(bus.win), 32'd1);
    bus.rb = 2'b11; cyc(2);
    new_game("win_newgame");

    // come-out craps: both dice in the same cycle, counter=6
    exp_q.push_back(pack(3'd6, 3'd6, 4'd0, 1'b0, 1'b1));
    press(2'b11, 3'd6);
    cyc(3);
    new_game("lose_newgame");

    // point 4, neutral roll, make the point
    roll(3'd2, 3'd2, pack(3'd2, 3'd2, 4'd4, 1'b0, 1'b0));
    chk("point_state", 32'(bus.dbg_state), 32'(POINT));
    roll(3'd1, 3'd5, pack(3'd1, 3'd5, 4'd4, 1'b0, 1'b0));
    roll(3'd3, 3'd1, pack(3'd3, 3'd1, 4'd4, 1'b1, 1'b0));
    new_game("make_newgame");

    // point 6 then seven out
    roll(3'd2, 3'd4, pack(3'd2, 3'd4, 4'd6, 1'b0, 1'b0));
    roll(3'd3, 3'd4, pack(3'd3, 3'd4, 4'd6, 1'b0, 1'b1));
    new_game("seven_newgame");

    // held button: one capture, counter=0 latches 1
    bus.counter = 3'd0; bus.rb = 2'b10; cyc();
    bus.counter = 3'd5; cyc(99);
    chk("hold_dice1", 32'(bus.dice1), 32'd1);
    chk("hold_busy", 32'(bus.busy), 32'd1);
    bus.rb = 2'b11; cyc();
    press(2'b01, 3'd2);
    chk("repress_dice1", 32'(bus.dice1), 32'd1);
    exp_q.push_back(pack(3'd1, 3'd1, 4'd0, 1'b0, 1'b1));  // counter=7 -> 1, sum 2
    press(2'b10, 3'd7);
    cyc(3);
    new_game("hold_newgame");

    // reset with one die captured
    press(2'b01, 3'd4);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("midrst_outputs", 32'(observed()), 32'(pack(3'd0, 3'd0, 4'd0, 1'b0, 1'b0)));
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_sel", 32'(bus.sel), 32'd0);
    chk("midrst_state", 32'(bus.dbg_state), 32'(COME_OUT));
    roll(3'd5, 3'd6, pack(3'd5, 3'd6, 4'd0, 1'b1, 1'b0));

    cyc(4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
